bcd_binary_seq: RTL and testbench
=================================

// Module: bcd_binary_seq
// PURPOSE
//  Sequential packed-BCD to binary converter (reverse double-dabble, shift-and-subtract-3).
//  - Inverse of the binary-to-BCD datapath; sits between BCD keypad/display logic and binary arithmetic units.
//  - One conversion in flight; valid/ready handshake on input and output.
//  - Latency: BIN_W iteration cycles per word.
// PARAMETERS
//  DIGITS  3   number of BCD digits on BCD input (4*DIGITS bits)
//  BIN_W   10  binary result width; must be >= ceil(log2(10**DIGITS)) (3 digits -> 10)
// PORTS
//  CLK        in   1         single clock, all state on rising edge
//  RST_N      in   1         asynchronous, active-low reset
//  BCD        in   4*DIGITS  packed BCD word, digit 0 in BCD[3:0]
//  IN_VALID   in   1         BCD word offered
//  IN_READY   out  1         converter can accept a word (state IDLE)
//  BIN        out  BIN_W     binary result, valid while OUT_VALID=1
//  OUT_VALID  out  1         result available
//  OUT_READY  in   1         consumer takes result
//  ERR        out  1         invalid digit (>9) in accepted word, qualified by OUT_VALID
// BEHAVIOUR
//  Reset (RST_N low, async):
//   - state=IDLE, shift regs=0, counter=0.
//   - BIN=0, OUT_VALID=0, ERR=0, IN_READY=1.
//   - Takes effect mid-conversion or mid-hold; in-flight word discarded, no OUT_VALID pulse.
//  FSM states IDLE, SHIFT, DONE:
//   - IDLE: IN_READY=1. On IN_VALID=1 at rising edge: load R<=BCD, B<=0, cnt<=BIN_W, state->SHIFT.
//   - SHIFT: IN_READY=0. Each edge performs one iteration:
//     - {R,B} <= {R,B} >> 1 (R LSB enters B MSB).
//     - Then every 4-bit nibble of new R that is >=8 has 3 subtracted.
//     - cnt decrements; on the edge where cnt goes 1->0, B holds the result and state->DONE.
//   - DONE: OUT_VALID=1, BIN=B, IN_READY=0. On OUT_READY=1 at edge: state->IDLE.
//  Timing:
//   - OUT_VALID rises exactly BIN_W cycles after the accept edge.
//   - BIN and ERR stay stable while OUT_VALID=1 and OUT_READY=0.
//  Handshake:
//   - No new accept in the cycle the result is consumed (IN_READY low in DONE).
//   - Minimum period per word: BIN_W+2 cycles.
//   - IN_VALID ignored outside IDLE; BCD sampled only on the accept edge.
//  Widths:
//   - Internal R is 4*DIGITS bits; nibble correction wraps in 4 bits.
//   - BIN_W above the minimum only shifts extra zeros into the upper bits; result still exact.
//  OUT_READY held high before DONE has no effect; result is still presented for >=1 cycle.
// CONFIGURATION
//  BCD_CHECK_EN defined:
//   - On accept, any nibble >9 sets an error flag; ERR=1 with OUT_VALID.
//   - BIN forced to 0 for that word; same latency and handshake.
//  BCD_CHECK_EN undefined:
//   - No digit check; ERR tied 0.
//   - BIN for invalid input is whatever the algorithm yields (not checked by bench).
// TESTING (DIGITS=3, BIN_W=10)
//  BCD=12'h000, OUT_READY=1 -> OUT_VALID after 10 cycles, BIN=0, ERR=0, back to IDLE next edge.
//  BCD=12'h999 -> BIN=10'd999 (0x3E7); BCD=12'h123 -> BIN=10'd123; OUT_VALID exactly 10 cycles after accept.
//  BCD=12'h456, OUT_READY=0 for 5 cycles after OUT_VALID -> BIN=456 held stable, IN_READY=0, then consumed.
//  IN_VALID toggled with new values (12'h777) during SHIFT -> ignored; first result 12'h456 -> 456 unaffected.
//  RST_N pulsed low at iteration 4 of BCD=12'h321 -> OUT_VALID=0, BIN=0, IN_READY=1 immediately; no stale result.
//  BCD_CHECK_EN: BCD=12'h1A5 -> ERR=1, BIN=0; then BCD=12'h105 -> ERR=0, BIN=105.

Source files
------------

// File: rtl/bcd_binary_seq_if.sv
// Handshake bundle for the packed-BCD to binary converter: BCD word in, binary result out.
interface bcd_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic [4*DIGITS-1:0] bcd;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    bin;
  logic                out_valid;
  logic                out_ready;
  logic                err;

  modport master (output bcd, in_valid, out_ready, input in_ready, bin, out_valid, err);
  modport slave  (input bcd, in_valid, out_ready, output in_ready, bin, out_valid, err);
endinterface

// File: rtl/bcd_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per cycle).
// Optional digit check enabled by defining BCD_CHECK_EN.
module bcd_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_binary_seq_if.slave  bus
);
  localparam int RW = 4*DIGITS;
  localparam int CW = $clog2(BIN_W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    r_q, r_sh, r_fix;
  logic [BIN_W-1:0] b_q, b_sh;
  logic [CW-1:0]    cnt_q;
  logic             err_q, bad, accept;
  logic             in_ready, out_valid;

  // One iteration: shift {R,B} right, then pull each nibble back into BCD range.
  always_comb begin
    {r_sh, b_sh} = {r_q, b_q} >> 1;
    r_fix = r_sh;
    for (int d = 0; d < DIGITS; d++)
      if (r_sh[4*d+3]) r_fix[4*d +: 4] = r_sh[4*d +: 4] - 4'd3;
  end

`ifdef BCD_CHECK_EN
  always_comb begin
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (bus.bcd[4*d +: 4] > 4'd9) bad = 1'b1;
  end
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = SHIFT;
      end
      SHIFT: if (cnt_q == CW'(1)) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_ready & bus.in_valid;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      r_q   <= bus.bcd;
      b_q   <= '0;
      cnt_q <= CW'(BIN_W);
      err_q <= bad;
    end else if (state_q == SHIFT) begin
      r_q   <= r_fix;
      b_q   <= b_sh;
      cnt_q <= cnt_q - CW'(1);
    end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.bin       = (out_valid && !err_q) ? b_q : '0;
  assign bus.err       = out_valid & err_q;
endmodule

// File: tb/tb_bcd_binary_seq.sv
// Scoreboard bench for bcd_binary_seq (DIGITS=3, BIN_W=10).
module tb_bcd_binary_seq;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  bcd_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus();
  bcd_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4*DIGITS-1:0] v);
    exp_t e;
    int   acc = 0;
    e.err = 1'b0;
    for (int d = DIGITS-1; d >= 0; d--) begin
      acc = acc*10 + int'(v[4*d +: 4]);
`ifdef BCD_CHECK_EN
      if (v[4*d +: 4] > 4'd9) e.err = 1'b1;
`endif
    end
    e.bin = e.err ? '0 : BIN_W'(acc);
    return e;
  endfunction

  // hold==0: out_ready held high throughout; noise: offer 12'h777 while busy
  task automatic run_word(input logic [11:0] v, input int hold, input bit noise);
    int n;
    exp_t e;
    logic [BIN_W-1:0] snap;
    @(negedge clk);
    bus.bcd = v; bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
    @(posedge clk);
    sb.push_back(model(v));
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy_ready", bus.in_ready, 0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      if (noise) begin bus.in_valid = 1'b1; bus.bcd = 12'h777; end
      @(posedge clk); n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("latency", n, BIN_W);
    if (!bus.out_valid) return;
    snap = bus.bin;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_bin", bus.bin, snap);
      chk("hold_ready", bus.in_ready, 0);
    end
    e = sb.pop_front();
    chk("bin", bus.bin, e.bin);
    chk("err", bus.err, e.err);
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("consumed", bus.out_valid, 0);
    chk("idle_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    logic [11:0] v;
    bus.bcd = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_bin", bus.bin, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ready", bus.in_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    run_word(12'h000, 0, 1'b0);
    run_word(12'h999, 1, 1'b0);
    run_word(12'h123, 1, 1'b0);
    run_word(12'h456, 5, 1'b0);
    run_word(12'h456, 1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      v = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
      run_word(v, i % 3, 1'b0);
    end

    // reset during iteration 4 of 12'h321
    @(negedge clk);
    bus.bcd = 12'h321; bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(12'h321));
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_bin", bus.bin, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("no_stale", seen, 0);

    run_word(12'h321, 1, 1'b0);
`ifdef BCD_CHECK_EN
    run_word(12'h1A5, 1, 1'b0);
    run_word(12'h105, 1, 1'b0);
    run_word(12'h90F, 0, 1'b0);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
